// File: rtl/accumulator_arbiter_pkg.sv
// Shared encodings for the two-requester accumulator arbiter: FSM states,
// requester IDs and the round-robin pick used when arbitrating in IDLE.
package accumulator_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Favour the requester that did not own the previous burst when both ask.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
      if (v0 && v1) begin
         return (last_grant == REQ0) ? REQ1 : REQ0;
      end else if (v1) begin
         return REQ1;
      end else begin
         return REQ0;
      end
   endfunction

endpackage

// File: rtl/accumulator_arbiter_accum_core.sv
// Registered running-sum datapath: synchronous clear, enabled add, and the
// carry-out of the addition currently presented on its inputs.
module accum_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             carry
);

   logic [WIDTH:0] sum_ext;

   assign sum_ext = {1'b0, out} + {1'b0, in};
   assign carry   = sum_ext[WIDTH];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out <= '0;
      end else if (clear) begin
         out <= '0;
      end else if (enable) begin
         out <= sum_ext[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/accumulator_arbiter.sv
// Round-robin owner of one shared feedback accumulator: grants a whole burst
// to one requester, sums its operands and hands back the total with id/overflow.
module accumulator_arbiter
   import accumulator_arbiter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req0_last,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   input  logic             req1_last,
   output logic             req1_ready,
   output logic             result_valid,
   output logic [WIDTH-1:0] result_data,
   output logic             result_id,
   output logic             result_overflow,
   input  logic             result_ready,
   output logic             busy
);

   state_t           state;
   logic             grant;
   logic             last_grant;
   logic             overflow;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] operand;
   logic             carry;
   logic             any_valid;
   logic             pick;
   logic             clear;
   logic             beat;
   logic             beat_last;

   assign any_valid = req0_valid | req1_valid;
   assign pick      = rr_pick(req0_valid, req1_valid, last_grant);
   assign clear     = (state == ST_IDLE) && any_valid;

   // Only the granted requester's lane reaches the adder; the other is ignored.
   assign operand   = (grant == REQ1) ? req1_data : req0_data;
   assign beat      = (state == ST_ACCUM) && ((grant == REQ1) ? req1_valid : req0_valid);
   assign beat_last = beat && ((grant == REQ1) ? req1_last : req0_last);

   accum_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .enable (beat),
      .in     (operand),
      .out    (acc),
      .carry  (carry)
   );

   // The sum is frozen from the last beat until the next grant, so the result
   // fields can be taken straight from the datapath and owner registers.
   assign result_data     = acc;
   assign result_id       = grant;
   assign result_overflow = overflow;

   // NOTE: every register, datapath included, is async-reset so a mid-burst reset discards all state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         grant        <= REQ0;
         last_grant   <= REQ1;
         overflow     <= 1'b0;
         req0_ready   <= 1'b0;
         req1_ready   <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  grant      <= pick;
                  overflow   <= 1'b0;
                  req0_ready <= (pick == REQ0);
                  req1_ready <= (pick == REQ1);
                  busy       <= 1'b1;
                  state      <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  overflow <= overflow | carry;
               end
               if (beat_last) begin
                  last_grant   <= grant;
                  req0_ready   <= 1'b0;
                  req1_ready   <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: begin
               req0_ready   <= 1'b0;
               req1_ready   <= 1'b0;
               result_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_arbiter.sv
// Scoreboard bench for accumulator_arbiter: expected results are queued when
// bursts are launched and compared as the DUT hands each result over.
module tb_accumulator_arbiter;

   typedef logic [15:0] ops_t [4];
   typedef struct packed {
      logic [15:0] data;
      logic        id;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready;
   logic        result_valid, result_id, result_overflow, busy;
   logic [15:0] result_data;
   logic        result_ready = 1'b1;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   hs0 = 0;
   int   hs1 = 0;

   accumulator_arbiter #(.WIDTH(16)) dut (
      .clk             (clk),
      .reset           (rst_n),
      .req0_valid      (req0_valid),
      .req0_data       (req0_data),
      .req0_last       (req0_last),
      .req0_ready      (req0_ready),
      .req1_valid      (req1_valid),
      .req1_data       (req1_data),
      .req1_last       (req1_last),
      .req1_ready      (req1_ready),
      .result_valid    (result_valid),
      .result_data     (result_data),
      .result_id       (result_id),
      .result_overflow (result_overflow),
      .result_ready    (result_ready),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit id, input bit v, input logic [15:0] d, input bit l);
      if (id) begin
         req1_valid = v; req1_data = d; req1_last = l;
      end else begin
         req0_valid = v; req0_data = d; req0_last = l;
      end
   endtask

   // Present n operands, waiting for each handshake; gap idle cycles between beats.
   task automatic send_burst(input bit id, input ops_t ops, input int n, input int gap, input bit term);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         drive(id, 1'b1, ops[i], term && (i == n - 1));
         begin
            int k = 0;
            do begin
               @(negedge clk);
               k++;
            end while (!(id ? req1_ready : req0_ready) && k < 200);
            if (k >= 200) begin
               check(id ? "req1_ready_timeout" : "req0_ready_timeout", 32'd0, 32'd1);
            end
         end
         @(posedge clk);
         #1;
         drive(id, 1'b0, 16'd0, 1'b0);
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) check("drain_timeout", sb.size(), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Result monitor: pops the scoreboard on every result handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && req0_valid && req0_ready) hs0++;
         if (rst_n && req1_valid && req1_ready) hs1++;
         if (rst_n && result_valid && result_ready) begin
            check("result_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("result_data", {16'd0, result_data}, {16'd0, e.data});
               check("result_id", {31'd0, result_id}, {31'd0, e.id});
               check("result_overflow", {31'd0, result_overflow}, {31'd0, e.ovf});
            end
         end
      end
   end

   initial begin
      // Reset state
      #12;
      check("rst_result_valid", {31'd0, result_valid}, 32'd0);
      check("rst_result_data", {16'd0, result_data}, 32'd0);
      check("rst_result_id", {31'd0, result_id}, 32'd0);
      check("rst_result_ovf", {31'd0, result_overflow}, 32'd0);
      check("rst_ready0", {31'd0, req0_ready}, 32'd0);
      check("rst_ready1", {31'd0, req1_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic burst 5,5,200 with grant latency check
      hs0 = 0;
      sb.push_back('{16'd210, 1'b0, 1'b0});
      drive(0, 1'b1, 16'd5, 1'b0);
      @(negedge clk);
      check("latency_ready0_idle", {31'd0, req0_ready}, 32'd0);
      check("latency_busy_idle", {31'd0, busy}, 32'd0);
      send_burst(0, '{16'd5, 16'd5, 16'd200, 16'd0}, 3, 0, 1'b1);
      wait_drain();
      check("req0_handshakes", hs0, 32'd3);

      // Simultaneous requests after reset: req0, then req1, then req0 again
      apply_reset();
      sb.push_back('{16'd11, 1'b0, 1'b0});
      sb.push_back('{16'd7, 1'b1, 1'b0});
      fork
         send_burst(0, '{16'd11, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
         send_burst(1, '{16'd7, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
      join
      sb.push_back('{16'd12, 1'b0, 1'b0});
      sb.push_back('{16'd13, 1'b1, 1'b0});
      fork
         send_burst(0, '{16'd12, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
         send_burst(1, '{16'd13, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
      join
      wait_drain();

      // Wrap-around and sticky overflow cleared on the next grant
      sb.push_back('{16'h0001, 1'b1, 1'b1});
      send_burst(1, '{16'hFFFF, 16'h0002, 16'd0, 16'd0}, 2, 0, 1'b1);
      wait_drain();
      sb.push_back('{16'd3, 1'b1, 1'b0});
      send_burst(1, '{16'd3, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
      wait_drain();

      // Bubbles in req0's burst while req1 waits
      sb.push_back('{16'd10, 1'b0, 1'b0});
      sb.push_back('{16'd8, 1'b1, 1'b0});
      fork
         send_burst(0, '{16'd4, 16'd6, 16'd0, 16'd0}, 2, 3, 1'b1);
         send_burst(1, '{16'd8, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
         begin
            int k = 0;
            int blocked_bad = 0;
            while (sb.size() > 1 && k < 300) begin
               @(negedge clk);
               if (req1_ready) blocked_bad++;
               k++;
            end
            check("req1_blocked_while_req0_owns", blocked_bad, 32'd0);
         end
      join
      wait_drain();

      // Result back-pressure: DONE holds steady for 5 cycles
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      sb.push_back('{16'd20, 1'b0, 1'b0});
      send_burst(0, '{16'd20, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
      begin
         int k = 0;
         while (!result_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (k >= 50) check("done_timeout", 32'd0, 32'd1);
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'd0, result_valid}, 32'd1);
         check("hold_data", {16'd0, result_data}, 32'd20);
         check("hold_ready0", {31'd0, req0_ready}, 32'd0);
         check("hold_ready1", {31'd0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      result_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("idle_after_take_valid", {31'd0, result_valid}, 32'd0);
      check("idle_after_take_busy", {31'd0, busy}, 32'd0);
      check("idle_result_held", {16'd0, result_data}, 32'd20);
      wait_drain();

      // Reset mid-burst discards the partial sum
      send_burst(0, '{16'd9, 16'd9, 16'd0, 16'd0}, 2, 0, 1'b0);
      @(negedge clk);
      check("midburst_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ready0", {31'd0, req0_ready}, 32'd0);
      check("midrst_ready1", {31'd0, req1_ready}, 32'd0);
      check("midrst_valid", {31'd0, result_valid}, 32'd0);
      check("midrst_data", {16'd0, result_data}, 32'd0);
      check("midrst_id", {31'd0, result_id}, 32'd0);
      check("midrst_ovf", {31'd0, result_overflow}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{16'd1, 1'b0, 1'b0});
      send_burst(0, '{16'd1, 16'd0, 16'd0, 16'd0}, 1, 0, 1'b1);
      wait_drain();

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/accumulator_arbiter.md
Name: accumulator_arbiter

Overview:
- Shares one WIDTH-bit feedback accumulator (running sum) between two requesters.
- Each requester streams a burst of operands over a valid/ready handshake. The burst is terminated by a last flag.
- The arbiter grants the accumulator to one requester per burst, round-robin. It clears the sum at burst start and returns the final sum with the winner's ID and an overflow flag.
- Sits between operand producers and the shared adder-with-feedback datapath.

Parameters:
- WIDTH, 16, operand/sum width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  in  1  requester 0 operand valid.
- req0_data  in  WIDTH  requester 0 operand.
- req0_last  in  1  requester 0 final operand of burst.
- req0_ready  out  1  requester 0 operand accepted when valid&ready.
- req1_valid  in  1  requester 1 operand valid.
- req1_data  in  WIDTH  requester 1 operand.
- req1_last  in  1  requester 1 final operand of burst.
- req1_ready  out  1  requester 1 operand accepted when valid&ready.
- result_valid  out  1  final sum available.
- result_data  out  WIDTH  final sum, modulo 2^WIDTH.
- result_id  out  1  requester that owned the burst.
- result_overflow  out  1  sum wrapped at least once during the burst.
- result_ready  in  1  consumer accepts result when valid&ready.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, acc=0, overflow=0, grant=0, last_grant=1.
  - All outputs 0, including result_data=0, result_id=0, result_overflow=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - reqX_ready=0.
  - If any reqX_valid: grant = requester other than last_grant if it is valid, else the only valid one. Then acc<=0, overflow<=0, state<=ACCUM.
  - Winner's first operand is not consumed in this cycle. Grant latency is 1 cycle.
- ACCUM:
  - req[grant]_ready=1; the other ready=0.
  - Each cycle with req[grant]_valid=1: acc <= acc + data, truncated to WIDTH. overflow <= overflow | carry-out.
  - valid=0 cycles are bubbles: acc held, no timeout.
  - If the beat carries last=1: state<=DONE, last_grant<=grant.
  - One operand per cycle maximum.
- DONE:
  - result_valid=1, result_data=acc, result_id=grant, result_overflow=overflow; all ready=0.
  - On result_ready=1: state<=IDLE.
  - result_data, result_id and result_overflow hold their values in IDLE until the next grant.
- Single-beat burst (valid&last in the first ACCUM cycle): result = that operand, 1 cycle in ACCUM.
- Simultaneous requests in IDLE: round-robin per above. First arbitration after reset favours requester 0.
- The non-granted requester's valid is ignored in ACCUM/DONE. It must hold its operand (standard handshake). Its ready stays 0.
- Wrap-around: 0xFFFF + 0x0002 = 0x0001 with overflow=1 for WIDTH=16. Overflow is sticky for the burst and cleared at the next grant.
- result_ready asserted in IDLE/ACCUM has no effect.
- Back-to-back: DONE→IDLE→ACCUM gives a minimum 2-cycle gap between bursts.
- Reset mid-burst: immediate return to IDLE with the reset values above. The partial sum is discarded and no result is produced.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - requester ID constants REQ0=1'b0, REQ1=1'b1.
- Sub-module accum_core (param WIDTH): ports clk, reset, clear, enable, in, out, carry.
  - Registered sum with synchronous clear and enable; carry = adder carry-out of the current addition.
  - The arbiter instantiates one accum_core and drives the FSM and handshake muxing around it.

Test Plan:
- Reset then req0 bursts 5,5,200(last) with result_ready=1 → result_valid=1, result_data=210, result_id=0, result_overflow=0; exactly 3 req0 handshakes; IDLE→ACCUM latency 1 cycle.
- req0 and req1 both valid in IDLE after reset → req0 granted first. req1 burst 7(last) is granted next → result 7, id=1. A following simultaneous request grants req0.
- req1 burst 0xFFFF, 0x0002(last) → result_data=0x0001, result_overflow=1. Next burst 3(last) → result 3, overflow=0.
- Bubbles: req0 drives 4, idle 3 cycles, then 6(last) → result 10. req1 valid throughout sees ready=0 until req0's result is taken.
- result_ready held 0 for 5 cycles in DONE → result_valid/result_data stable, both readys 0. result_ready=1 → IDLE next cycle.
- Assert reset (low) mid-burst after operands 9,9 → all outputs 0 immediately. After release, burst 1(last) → result 1, not 19.
